// File: rtl/btb_update_ctrl.sv
// BTB write-side controller: builds entries from branch resolutions, queues them, drains one RAM write per cycle,
// and sweeps all entries to zero after reset/flush. Define BTB_HYST_EN for 2-bit hysteresis counters.
module btb_update_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IDX_W      = 7,
    parameter int unsigned TAG_W      = 3,
    parameter int unsigned ENTRY_W    = 36
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_req,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [31:0]        upd_pc,
    input  logic [31:0]        upd_target,
    input  logic               upd_taken,
    input  logic               upd_hit,
    input  logic [1:0]         upd_ctr,
    output logic               init_busy,
    output logic               ram_we,
    output logic [IDX_W-1:0]   ram_a,
    output logic [ENTRY_W-1:0] ram_d
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    typedef struct packed {
        logic [IDX_W-1:0]   idx;
        logic [ENTRY_W-1:0] entry;
    } item_t;

    state_t             state, state_next;
    logic [IDX_W-1:0]   sweep, sweep_next;
    item_t              mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, wr_ptr_next, rd_ptr, rd_ptr_next;
    logic [CNT_W-1:0]   count, count_next;
    logic               ram_we_next, init_busy_next;
    logic [IDX_W-1:0]   ram_a_next;
    logic [ENTRY_W-1:0] ram_d_next;
    logic               fifo_full, accept, need_write, push, pop;
    logic [1:0]         ctr_new;
    logic [ENTRY_W-1:0] entry;
    logic [TAG_W-1:0]   tag;
    item_t              head;
    logic               unused_bits;

    assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
    assign upd_ready = (state == S_RUN) && !fifo_full && !flush_req;
    assign accept    = upd_valid && upd_ready;
    assign tag       = upd_pc[IDX_W+2 +: TAG_W];
    assign head      = mem[rd_ptr];
    assign push      = accept && need_write;
    assign pop       = (state == S_RUN) && (count != '0) && !flush_req;

    // Entry construction and write filter
    always_comb begin
        ctr_new    = 2'b11;
        entry      = '0;
        need_write = upd_taken || upd_hit;
`ifdef BTB_HYST_EN
        if (upd_hit) begin
            if (upd_taken) ctr_new = (upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'd1;
            else           ctr_new = (upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'd1;
        end else begin
            ctr_new = 2'b10;
        end
        if (ctr_new != 2'b00) entry = {1'b1, ctr_new, tag, upd_target[31:2]};
`else
        if (upd_taken) entry = {1'b1, ctr_new, tag, upd_target[31:2]};
`endif
    end

`ifdef BTB_HYST_EN
    assign unused_bits = ^{upd_pc[31:IDX_W+TAG_W+2], upd_pc[1:0], upd_target[1:0]};
`else
    assign unused_bits = ^{upd_pc[31:IDX_W+TAG_W+2], upd_pc[1:0], upd_target[1:0], upd_ctr};
`endif

    // Next-state, FIFO bookkeeping and registered RAM port values
    always_comb begin
        state_next  = state;
        sweep_next  = sweep;
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        ram_we_next = 1'b0;
        ram_a_next  = ram_a;
        ram_d_next  = ram_d;
        if (flush_req) begin
            state_next  = S_INIT;
            sweep_next  = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            case (state)
                S_INIT: begin
                    ram_we_next = 1'b1;
                    ram_a_next  = sweep;
                    ram_d_next  = '0;
                    sweep_next  = sweep + IDX_W'(1);
                    if (&sweep) state_next = S_RUN;
                end
                S_RUN: begin
                    if (pop) begin
                        ram_we_next = 1'b1;
                        ram_a_next  = head.idx;
                        ram_d_next  = head.entry;
                        rd_ptr_next = rd_ptr + PTR_W'(1);
                    end
                end
                default: state_next = S_INIT;
            endcase
            if (push) wr_ptr_next = wr_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_next = count + CNT_W'(1);
                2'b01:   count_next = count - CNT_W'(1);
                default: count_next = count;
            endcase
        end
        init_busy_next = (state_next == S_INIT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_INIT;
            sweep     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ram_we    <= 1'b0;
            ram_a     <= '0;
            ram_d     <= '0;
            init_busy <= 1'b1;
        end else begin
            state     <= state_next;
            sweep     <= sweep_next;
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            count     <= count_next;
            ram_we    <= ram_we_next;
            ram_a     <= ram_a_next;
            ram_d     <= ram_d_next;
            init_busy <= init_busy_next;
        end
    end

    // Queue storage needs no reset; occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{idx: upd_pc[IDX_W+1:2], entry: entry};
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Randomized bench for btb_update_ctrl against a queue-based reference model; honours BTB_HYST_EN.
module tb_btb_update_ctrl;

`ifdef BTB_HYST_EN
    localparam bit HYST = 1'b1;
`else
    localparam bit HYST = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_req, upd_valid, upd_ready, upd_taken, upd_hit;
    logic [31:0] upd_pc, upd_target;
    logic [1:0]  upd_ctr;
    logic        init_busy, ram_we;
    logic [6:0]  ram_a;
    logic [35:0] ram_d;

    always #5 clk = ~clk;

    btb_update_ctrl dut (
        .clk(clk), .rst(rst), .flush_req(flush_req),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_hit(upd_hit), .upd_ctr(upd_ctr),
        .init_busy(init_busy), .ram_we(ram_we), .ram_a(ram_a), .ram_d(ram_d)
    );

    typedef struct { logic [6:0] a; logic [35:0] d; } wr_t;

    int          n_checks = 0;
    int          n_errors = 0;
    wr_t         q[$];
    bit          m_run;
    int          m_sweep;
    bit          m_we;
    logic [6:0]  m_a;
    logic [35:0] m_d;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns 1 when the resolution must produce a RAM write; e is the entry to write
    function automatic bit model_entry(input logic taken, input logic hit, input logic [1:0] ctr,
                                       input logic [31:0] pc, input logic [31:0] tgt,
                                       output logic [35:0] e);
        int c;
        e = '0;
        if (!taken && !hit) return 1'b0;
        if (HYST) begin
            if (!hit) c = 2;
            else begin
                c = taken ? int'(ctr) + 1 : int'(ctr) - 1;
                if (c > 3) c = 3;
                if (c < 0) c = 0;
            end
            if (c != 0) e = {1'b1, 2'(c), pc[11:9], tgt[31:2]};
        end else begin
            if (taken) e = {1'b1, 2'b11, pc[11:9], tgt[31:2]};
        end
        return 1'b1;
    endfunction

    // One clock: drive at negedge, check ready, advance model, check registered outputs after the edge
    task automatic step(input logic fl, input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic tk, input logic h, input logic [1:0] c);
        bit          exp_ready;
        bit          nw;
        logic [35:0] e;
        wr_t         w;
        flush_req = fl; upd_valid = v; upd_pc = pc; upd_target = tgt;
        upd_taken = tk; upd_hit = h; upd_ctr = c;
        #1;
        exp_ready = m_run && (q.size() < DEPTH) && !fl;
        check("upd_ready", 64'(upd_ready), 64'(exp_ready));
        if (fl) begin
            q.delete(); m_run = 0; m_sweep = 0; m_we = 0;
        end else if (!m_run) begin
            m_we = 1; m_a = 7'(m_sweep); m_d = '0;
            m_sweep++;
            if (m_sweep == 128) m_run = 1;
        end else begin
            if (q.size() > 0) begin
                w = q.pop_front(); m_we = 1; m_a = w.a; m_d = w.d;
            end else begin
                m_we = 0;
            end
            if (v && exp_ready) begin
                nw = model_entry(tk, h, c, pc, tgt, e);
                if (nw) q.push_back('{a: pc[8:2], d: e});
            end
        end
        @(posedge clk); #1;
        check("ram_we", 64'(ram_we), 64'(m_we));
        if (m_we) begin
            check("ram_a", 64'(ram_a), 64'(m_a));
            check("ram_d", 64'(ram_d), 64'(m_d));
        end
        check("init_busy", 64'(init_busy), 64'(!m_run));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        rst = 1'b0; flush_req = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_target = '0;
        upd_taken = 1'b0; upd_hit = 1'b0; upd_ctr = '0;
        m_run = 0; m_sweep = 0; m_we = 0; m_a = '0; m_d = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ram_we", 64'(ram_we), 64'd0);
        check("rst_ram_a", 64'(ram_a), 64'd0);
        check("rst_ram_d", 64'(ram_d), 64'd0);
        check("rst_init_busy", 64'(init_busy), 64'd1);
        check("rst_upd_ready", 64'(upd_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Initial sweep of 128 zero writes
        idle(128);
        #1;
        check("sweep_done_ready", 64'(upd_ready), 64'd1);
        check("sweep_done_busy", 64'(init_busy), 64'd0);

        // Taken miss at pc 0xA04: idx 1, tag 5, written two edges after acceptance
        step(1'b0, 1'b1, 32'h0000_0A04, 32'h0000_1000, 1'b1, 1'b0, 2'b00);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
        check("t2_we", 64'(ram_we), 64'd1);
        check("t2_a", 64'(ram_a), 64'h01);
        check("t2_d", 64'(ram_d), HYST ? 64'hD_4000_0400 : 64'hF_4000_0400);

        // Hit with ctr 01, not taken: invalidation in both modes
        step(1'b0, 1'b1, 32'h0000_0A08, 32'h0000_2000, 1'b0, 1'b1, 2'b01);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
        check("t3_inval", 64'(ram_d), 64'd0);
        // Hit with ctr 11, taken: counter saturates at 11
        step(1'b0, 1'b1, 32'h0000_0A0C, 32'h0000_3000, 1'b1, 1'b1, 2'b11);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
        check("t3_sat", 64'(ram_d[34:33]), 64'd3);
        // Not-taken miss: accepted, dropped
        step(1'b0, 1'b1, 32'h0000_0A10, 32'h0000_4000, 1'b0, 1'b0, 2'b10);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
        check("t3_drop", 64'(ram_we), 64'd0);

        // Back-to-back taken resolutions
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 32'($urandom) & 32'h0000_0FFC, $urandom, 1'b1, 1'($urandom), 2'($urandom));
        idle(2);

        // Flush with a write pending: queued write discarded, sweep restarts at 0
        step(1'b0, 1'b1, 32'h0000_0F00, 32'h0000_5000, 1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
        check("t4_restart_we", 64'(ram_we), 64'd1);
        check("t4_restart_a", 64'(ram_a), 64'd0);

        // Offers during the sweep are refused; flush again at sweep ptr 60
        for (int i = 0; i < 59; i++)
            step(1'b0, 1'b1, $urandom, $urandom, 1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b1, $urandom, $urandom, 1'b1, 1'b0, 2'b00);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
        check("t6_restart_a", 64'(ram_a), 64'd0);
        idle(127);

        // Randomized traffic with occasional flushes and index collisions
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 3) != 0),
                 32'($urandom) & 32'h0000_0F1C, $urandom,
                 1'($urandom), 1'($urandom), 2'($urandom));
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
